mux_scan_ctrl: RTL and testbench

- Sequencer that sits directly upstream and downstream of the team's mux4x1.
- Drives the mux select lines s1/s0 through channels 0..3.
- Waits a settle time on each channel, then samples the mux output y.
- Assembles the four samples into a 4-bit frame, delivered over a valid/ready handshake.
- Supports single-shot or continuous scanning.

---
 rtl/mux_scan_pkg.sv | 35 +++
 rtl/mux_scan_timer.sv | 55 +++++
 rtl/mux_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the mux4x1 scan sequencer.
//
// Contents:
//   NCH / CH_W  - channel count of the downstream mux and its select width
//   LAST_CH     - highest channel index; the scan finishes after this one
//   CNT_W       - width of the dwell counter
//   state_t     - controller states (IDLE, SCAN, DONE)
//   frame_t     - one captured frame, bit k holds the sample taken on channel k
//   frame_parity_f - XOR reduction of a frame
//
// Optional feature macro used elsewhere in the slice: MUX_SCAN_PARITY_EN.
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NCH   = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 8;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [NCH-1:0] frame_t;

    function automatic logic frame_parity_f(input frame_t f);
        return ^f;
    endfunction

endpackage : mux_scan_pkg

// File: rtl/mux_scan_timer.sv
// -----------------------------------------------------------------------------
// mux_scan_timer
// Dwell counter for one channel of a scan. While enabled it counts
// 0..DWELL-1 and wraps to 0; the controller uses the two pulses to know when
// the mux output has settled and when the dwell on a channel is over.
//
// Parameters:
//   DWELL  - cycles per channel, legal range 2..255
//   SETTLE - count at which the mux output is sampled, legal range 0..DWELL-2
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   clear        in   force the count to 0 (held while not scanning)
//   en           in   advance the count this edge
//   sample_pulse out  high while enabled and count == SETTLE
//   last_pulse   out  high while enabled and count == DWELL-1
// -----------------------------------------------------------------------------
module mux_scan_timer
    import mux_scan_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic sample_pulse,
    output logic last_pulse
);

    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] LAST_AT   = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST_AT);

    // The count restarts at DWELL-1, so it never reaches the 8-bit wrap point.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every register so all flops see
        // pre-edge values regardless of block ordering in simulation.
        if (!rst_n || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign sample_pulse = en && (r_cnt == SAMPLE_AT);
    assign last_pulse   = en && w_at_last;

endmodule : mux_scan_timer

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Sequencer wrapped around a mux4x1: walks the select lines through channels
// 0..3, samples the mux output once per channel after it has settled, and
// hands the four samples to a consumer as one frame over valid/ready.
// Single-shot (start pulse) or continuous (rescan after each handshake).
//
// Parameters:
//   DWELL  - cycles per channel, legal range 2..255
//   SETTLE - sample offset within a dwell, legal range 0..DWELL-2
//
// Optional feature: define MUX_SCAN_PARITY_EN to add output frame_parity,
// the XOR of the frame bits, loaded and held together with frame.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   begin a scan, only acted on in IDLE
//   continuous   in   rescan after each handshake (examined at the handshake)
//   y_in         in   mux4x1 output
//   s1, s0       out  mux select, {s1,s0} = current channel
//   busy         out  high while scanning or holding a frame
//   frame        out  captured samples, frame[k] = y_in seen on channel k
//   frame_parity out  (MUX_SCAN_PARITY_EN only) XOR of frame
//   frame_valid  out  frame is available
//   frame_ready  in   consumer accepts the frame
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           continuous,
    input  logic           y_in,
    output logic           s1,
    output logic           s0,
    output logic           busy,
    output logic [NCH-1:0] frame,
`ifdef MUX_SCAN_PARITY_EN
    output logic           frame_parity,
`endif
    output logic           frame_valid,
    input  logic           frame_ready
);

    state_t          r_state;
    logic [CH_W-1:0] r_ch;
    logic [CH_W-1:0] r_sel;
    logic            r_busy;
    frame_t          r_shadow;
    frame_t          r_frame;
    logic            r_valid;

    logic            w_scanning;
    logic            w_sample;
    logic            w_last;
    logic            w_handshake;

    assign w_scanning  = (r_state == SCAN);
    assign w_handshake = (r_state == DONE) && r_valid && frame_ready;

    // Counter is held at zero outside SCAN, so every scan (from start or from
    // a continuous handshake) begins its first dwell at count 0.
    mux_scan_timer #(
        .DWELL  (DWELL),
        .SETTLE (SETTLE)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!w_scanning),
        .en           (w_scanning),
        .sample_pulse (w_sample),
        .last_pulse   (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the shadow sample register is reset too; it is only four
            // flops and a defined value keeps the first frame deterministic.
            r_state  <= IDLE;
            r_ch     <= '0;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_shadow <= '0;
            r_frame  <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sel <= '0;
                    if (start) begin
                        r_state <= SCAN;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                SCAN: begin
                    if (w_sample) begin
                        r_shadow[r_ch] <= y_in;
                    end
                    if (w_last) begin
                        if (r_ch != LAST_CH) begin
                            // Select moves together with the channel index so
                            // the mux sees the new channel for the full dwell.
                            r_ch  <= r_ch + CH_W'(1);
                            r_sel <= r_ch + CH_W'(1);
                        end else begin
                            // SETTLE < DWELL-1, so the last channel's sample
                            // is already in the shadow register here.
                            r_frame <= r_shadow;
                            r_valid <= 1'b1;
                            r_sel   <= '0;
                            r_ch    <= '0;
                            r_state <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (continuous) begin
                            // Straight back into a scan; select is already 00.
                            r_state <= SCAN;
                            r_ch    <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_ch    <= '0;
                    r_sel   <= '0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_parity;

    // Loaded on the same edge as frame, from the same shadow value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_scanning && w_last && (r_ch == LAST_CH)) begin
            r_parity <= frame_parity_f(r_shadow);
        end
    end

    assign frame_parity = r_parity;
`endif

    assign s1          = r_sel[1];
    assign s0          = r_sel[0];
    assign busy        = r_busy;
    assign frame       = r_frame;
    assign frame_valid = r_valid;

endmodule : mux_scan_ctrl

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Self-checking bench for mux_scan_ctrl driving a behavioural mux4x1.
// Expected select sequence and frame come from the scan rules directly:
// cycle t of a scan shows channel t/DWELL, and the frame equals the mux
// input vector held during the scan.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    localparam int DWELL  = 4;
    localparam int SETTLE = 1;
    localparam int NCYC   = 4 * DWELL;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       continuous;
    logic       y_in;
    logic       s1;
    logic       s0;
    logic       busy;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;
`ifdef MUX_SCAN_PARITY_EN
    logic       frame_parity;
`endif

    // Behavioural mux4x1 inputs i3..i0.
    logic [3:0] i_vec;

    int checks   = 0;
    int failures = 0;

    assign y_in = i_vec[{s1, s0}];

    mux_scan_ctrl #(
        .DWELL  (DWELL),
        .SETTLE (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .continuous   (continuous),
        .y_in         (y_in),
        .s1           (s1),
        .s0           (s0),
        .busy         (busy),
        .frame        (frame),
`ifdef MUX_SCAN_PARITY_EN
        .frame_parity (frame_parity),
`endif
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the edge that entered SCAN (start or continuous
    // handshake). Checks the select walk for the whole scan, then the frame.
    task automatic scan_cycles(input logic [3:0] exp, input string name,
                               input int start_at);
        for (int t = 0; t < NCYC; t++) begin
            checks++;
            if ({s1, s0} !== 2'(t / DWELL) || frame_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s_seq t=%0d got sel=%b valid=%b busy=%b expected sel=%0d valid=0 busy=1",
                         name, t, {s1, s0}, frame_valid, busy, t / DWELL);
            end
            start = (t == start_at);
            tick();
        end
        start = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame !== exp || {s1, s0} !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_frame got valid=%b frame=%b sel=%b busy=%b expected valid=1 frame=%b sel=00 busy=1",
                     name, frame_valid, frame, {s1, s0}, busy, exp);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if (frame_parity !== ^exp) begin
            failures++;
            $display("FAIL %s_parity got %b expected %b", name, frame_parity, ^exp);
        end
`endif
    endtask

    // Hold ready low for n cycles and confirm the frame is held untouched.
    task automatic hold_frame(input logic [3:0] exp, input int n, input string name);
        frame_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            checks++;
            if (frame_valid !== 1'b1 || frame !== exp || {s1, s0} !== 2'b00 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s_hold k=%0d got valid=%b frame=%b sel=%b busy=%b expected valid=1 frame=%b sel=00 busy=1",
                         name, k, frame_valid, frame, {s1, s0}, busy, exp);
            end
        end
    endtask

    // One-cycle ready pulse; afterwards valid is low and busy as given.
    task automatic handshake(input logic exp_busy, input logic [3:0] exp, input string name);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || busy !== exp_busy || {s1, s0} !== 2'b00 || frame !== exp) begin
            failures++;
            $display("FAIL %s_hs got valid=%b busy=%b sel=%b frame=%b expected valid=0 busy=%b sel=00 frame=%b",
                     name, frame_valid, busy, {s1, s0}, frame, exp_busy, exp);
        end
    endtask

    // Idle for n cycles: nothing may appear.
    task automatic expect_quiet(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            tick();
            checks++;
            if (frame_valid !== 1'b0 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
                failures++;
                $display("FAIL %s_quiet k=%0d got valid=%b busy=%b sel=%b expected valid=0 busy=0 sel=00",
                         name, k, frame_valid, busy, {s1, s0});
            end
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b1;
        continuous  = 1'b0;
        frame_ready = 1'b0;
        i_vec       = 4'b0000;
        repeat (3) tick();
        checks++;
        if ({s1, s0} !== 2'b00) begin
            failures++; $display("FAIL reset_sel got %b expected 00", {s1, s0});
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got %b expected 0", busy);
        end
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got %b expected 0", frame_valid);
        end
        checks++;
        if (frame !== 4'b0000) begin
            failures++; $display("FAIL reset_frame got %b expected 0000", frame);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if (frame_parity !== 1'b0) begin
            failures++; $display("FAIL reset_parity got %b expected 0", frame_parity);
        end
`endif
        rst_n = 1'b1;
        start = 1'b0;
        expect_quiet(2, "post_reset");
    endtask

    task automatic test_single_scan();
        i_vec = 4'b1110;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(4'b1110, "single", -1);
        handshake(1'b0, 4'b1110, "single");
        expect_quiet(3, "single");
    endtask

    task automatic test_backpressure();
        i_vec = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(4'b0101, "bp", -1);
        hold_frame(4'b0101, 10, "bp");
        handshake(1'b0, 4'b0101, "bp");
        frame_ready = 1'b1;
        expect_quiet(4, "bp_extra_ready");
        frame_ready = 1'b0;
    endtask

    task automatic test_continuous();
        logic [3:0] third;
        continuous  = 1'b1;
        frame_ready = 1'b1;
        i_vec       = 4'b1110;
        start       = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(4'b1110, "cont1", -1);
        // Change inputs before the next scan's first sample.
        i_vec = 4'b1001;
        tick();
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b1 || {s1, s0} !== 2'b00) begin
            failures++;
            $display("FAIL cont1_hs got valid=%b busy=%b sel=%b expected valid=0 busy=1 sel=00",
                     frame_valid, busy, {s1, s0});
        end
        scan_cycles(4'b1001, "cont2", -1);
        third = 4'($urandom_range(0, 15));
        i_vec = third;
        tick();
        // Dropped mid-scan: this frame still completes, then the block idles.
        continuous = 1'b0;
        scan_cycles(third, "cont3", -1);
        tick();
        frame_ready = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
            failures++;
            $display("FAIL cont3_hs got valid=%b busy=%b sel=%b expected valid=0 busy=0 sel=00",
                     frame_valid, busy, {s1, s0});
        end
        expect_quiet(3, "cont_end");
    endtask

    task automatic test_reset_mid_scan();
        i_vec = 4'b0011;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2 * DWELL + 1) tick();
        checks++;
        if ({s1, s0} !== 2'b10) begin
            failures++; $display("FAIL rst_mid_ch got sel=%b expected 10", {s1, s0});
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({s1, s0} !== 2'b00 || busy !== 1'b0 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle got sel=%b busy=%b valid=%b expected sel=00 busy=0 valid=0",
                     {s1, s0}, busy, frame_valid);
        end
        expect_quiet(2 * NCYC, "rst_mid");
        i_vec = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(4'b1010, "rst_mid_rescan", -1);
        handshake(1'b0, 4'b1010, "rst_mid_rescan");
    endtask

    task automatic test_ignored_start();
        i_vec = 4'b1110;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(4'b1110, "ign", 5);
        start = 1'b1;
        hold_frame(4'b1110, 2, "ign_done");
        start = 1'b0;
        handshake(1'b0, 4'b1110, "ign");
        expect_quiet(2 * NCYC, "ign");
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        for (int n = 0; n < 6; n++) begin
            pat   = 4'($urandom_range(0, 15));
            i_vec = pat;
            start = 1'b1;
            tick();
            start = 1'b0;
            scan_cycles(pat, "rand", -1);
            hold_frame(pat, $urandom_range(0, 6), "rand");
            handshake(1'b0, pat, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_backpressure();
        test_continuous();
        test_reset_mid_scan();
        test_ignored_start();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
